// File: rtl/imem_sync.sv
// Synchronous-read instruction memory with a valid/ready fetch port, fault flags and a load port.
// Optional build macro IMEM_PARITY_EN adds per-word even parity and widens rsp_fault to 3 bits.
module imem_sync #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 512,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [PC_W-1:0]    req_pc,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic [PC_W-1:0]    rsp_pc,
`ifdef IMEM_PARITY_EN
    output logic [2:0]         rsp_fault,
`else
    output logic [1:0]         rsp_fault,
`endif
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [INSTR_W-1:0] wr_data,
    output logic [31:0]        fetch_cnt
);

`ifdef IMEM_PARITY_EN
    localparam int FAULT_W = 3;
`else
    localparam int FAULT_W = 2;
`endif

    // Handshake: a request transfers on a cycle where req_valid && req_ready;
    // a response transfers on a cycle where rsp_valid && rsp_ready.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t               state_q;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [PC_W-1:0]      pc_q;
    logic [FAULT_W-1:0]   fault_q, fault_d;
    logic [31:0]          cnt_q;

    logic [INSTR_W-1:0]   mem_q [DEPTH] = '{default: '0};
`ifdef IMEM_PARITY_EN
    logic                 par_q [DEPTH] = '{default: 1'b0};
`endif

    logic                 accept;
    logic [IDX_W-1:0]     rd_idx;
    logic                 misaligned;
    logic                 out_of_range;

    assign req_ready    = (state_q == EMPTY) || rsp_ready;
    assign accept       = req_valid && req_ready;
    assign rd_idx       = req_pc[IDX_W+1:2];
    assign misaligned   = |req_pc[1:0];
    assign out_of_range = |req_pc[PC_W-1:IDX_W+2];

    always_comb begin
        fault_d    = '0;
        fault_d[0] = misaligned;
        fault_d[1] = out_of_range;
`ifdef IMEM_PARITY_EN
        // Parity is only meaningful for a well-formed address.
        fault_d[2] = !misaligned && !out_of_range && ((^mem_q[rd_idx]) != par_q[rd_idx]);
`endif
        instr_d = (|fault_d) ? '0 : mem_q[rd_idx];
    end

    // Memory is never reset; the read above sees the pre-edge word (read-before-write).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
`ifdef IMEM_PARITY_EN
            par_q[wr_idx] <= ^wr_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            instr_q <= '0;
            pc_q    <= '0;
            fault_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            state_q <= FULL;
            instr_q <= instr_d;
            pc_q    <= req_pc;
            fault_q <= fault_d;
            cnt_q   <= cnt_q + 32'd1;
        end else if (rsp_ready) begin
            state_q <= EMPTY;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_instr = instr_q;
    assign rsp_pc    = pc_q;
    assign rsp_fault = fault_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_imem_sync.sv
// Directed bench for imem_sync: fetch ordering, stall/drain, faults, read-before-write, async reset.
module tb_imem_sync;

`ifdef IMEM_PARITY_EN
    localparam int FW = 3;
`else
    localparam int FW = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [63:0]   req_pc;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_instr;
    logic [63:0]   rsp_pc;
    logic [FW-1:0] rsp_fault;
    logic          wr_en;
    logic [8:0]    wr_idx;
    logic [31:0]   wr_data;
    logic [31:0]   fetch_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] prog [4];

    imem_sync dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_pc    (rsp_pc),
        .rsp_fault (rsp_fault),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [8:0] idx, input logic [31:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] instr,
                             input logic [63:0] pc, input logic [FW-1:0] fault);
        check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, "_instr"}, 64'(rsp_instr), 64'(instr));
        check({tag, "_pc"},    rsp_pc,         pc);
        check({tag, "_fault"}, 64'(rsp_fault), 64'(fault));
    endtask

    // One accepted fetch with rsp_ready=1; checks the response on the next falling edge.
    task automatic fetch_one(input string tag, input logic [63:0] pc,
                             input logic [31:0] instr, input logic [FW-1:0] fault);
        @(negedge clk);
        req_valid = 1'b1;
        req_pc    = pc;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_rsp(tag, instr, pc, fault);
    endtask

    initial begin
        logic [63:0] pc_e;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_pc    = '0;
        rsp_ready = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;
        prog[0] = 32'hF84002A0;
        prog[1] = 32'hF84002A1;
        prog[2] = 32'h8B000023;
        prog[3] = 32'hF80002A3;

        #12;
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_instr", 64'(rsp_instr), 64'd0);
        check("rst_pc",    rsp_pc,         64'd0);
        check("rst_fault", 64'(rsp_fault), 64'd0);
        check("rst_cnt",   64'(fetch_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) write_word(9'(i), prog[i]);

        // Back-to-back fetches, one result per cycle
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                pc_e = exp_q.pop_front();
                check_rsp("b2b", prog[pc_e[3:2]], pc_e, '0);
            end
            check("b2b_ready", 64'(req_ready), 64'd1);
            req_valid = 1'b1;
            req_pc    = 64'(i * 4);
            exp_q.push_back(32'(i * 4));
        end
        @(negedge clk);
        req_valid = 1'b0;
        pc_e = exp_q.pop_front();
        check_rsp("b2b", prog[pc_e[3:2]], pc_e, '0);
        check("b2b_cnt", 64'(fetch_cnt), 64'd4);
        @(negedge clk);
        check("drain_empty", 64'(rsp_valid), 64'd0);

        // Stall with a pending request behind it
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc    = 64'd4;
        @(negedge clk);
        req_pc = 64'd8;
        for (int i = 0; i < 3; i++) begin
            check_rsp("stall", 32'hF84002A1, 64'd4, '0);
            check("stall_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        check("stall_cnt", 64'(fetch_cnt), 64'd5);
        rsp_ready = 1'b1;
        #1;
        check("drain_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check_rsp("drain_next", 32'h8B000023, 64'd8, '0);
        check("drain_cnt", 64'(fetch_cnt), 64'd6);

        // Faults, including an out-of-range PC that would alias idx3
        fetch_one("mis",  64'h6,   32'h0, FW'(1));
        fetch_one("oor",  64'h80C, 32'h0, FW'(2));
        fetch_one("both", 64'h802, 32'h0, FW'(3));
        fetch_one("top",  64'h8000_0000_0000_0004, 32'h0, FW'(2));
        check("fault_cnt", 64'(fetch_cnt), 64'd10);

`ifdef IMEM_PARITY_EN
        begin
            logic p;
            p = dut.par_q[1];
            force dut.par_q[1] = ~p;
            fetch_one("parity", 64'h4, 32'h0, FW'(4));
            release dut.par_q[1];
            fetch_one("parity_ok", 64'h0, 32'hF84002A0, '0);
        end
`endif

        // Write and fetch to the same index in one cycle returns the old word
        @(negedge clk);
        wr_en     = 1'b1;
        wr_idx    = 9'd2;
        wr_data   = 32'hDEADBEEF;
        req_valid = 1'b1;
        req_pc    = 64'd8;
        @(negedge clk);
        wr_en = 1'b0;
        check_rsp("rbw_old", 32'h8B000023, 64'd8, '0);
        @(negedge clk);
        req_valid = 1'b0;
        check_rsp("rbw_new", 32'hDEADBEEF, 64'd8, '0);

        // Write while FULL leaves the held response alone
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc    = 64'd12;
        @(negedge clk);
        req_valid = 1'b0;
        wr_en     = 1'b1;
        wr_idx    = 9'd3;
        wr_data   = 32'h12345678;
        @(negedge clk);
        wr_en = 1'b0;
        check_rsp("wr_full", 32'hF80002A3, 64'd12, '0);

        // Asynchronous reset while FULL, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(rsp_valid), 64'd0);
        check("arst_instr", 64'(rsp_instr), 64'd0);
        check("arst_pc",    rsp_pc,         64'd0);
        check("arst_cnt",   64'(fetch_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fetch_one("keep2", 64'd8,  32'hDEADBEEF, '0);
        fetch_one("keep3", 64'd12, 32'h12345678, '0);
        fetch_one("keep0", 64'd0,  32'hF84002A0, '0);
        check("post_cnt", 64'(fetch_cnt), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
